// File: rtl/morse_ram_writer_if.sv
// Write-side bus of an SB_RAM40_4K as driven by the Morse recorder.
// The read side of the RAM stays with the playback block and is not part of this bus.
interface morse_ram_writer_if;
    logic [10:0] ram_waddr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic        ram_wclke;

    modport master (output ram_waddr, output ram_wdata, output ram_we, output ram_wclke);
    modport slave  (input  ram_waddr, input  ram_wdata, input  ram_we, input  ram_wclke);
endinterface

// File: rtl/morse_ram_writer.sv
// Samples a debounced Morse key once per time unit and writes one word per unit into RAM,
// in the same image format the LED playback block reads back.
module morse_ram_writer #(
    parameter int LOG2UNIT   = 20,
    parameter int DEPTH      = 6,
    parameter int STOP_UNITS = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_in,
    input  logic                arm,
    morse_ram_writer_if.master  ram,
    output logic                recording,
    output logic                done,
    output logic                full,
    output logic [DEPTH:0]      length
);
    localparam int             ZW   = $clog2(STOP_UNITS + 1);
    localparam logic [DEPTH:0] CAP  = {1'b1, {DEPTH{1'b0}}};
    localparam logic [ZW-1:0]  STOP = ZW'(STOP_UNITS);

    typedef enum logic [1:0] {IDLE, RECORD, DONE} state_t;

    state_t              state_q, state_d;
    logic [1:0]          sync_q;
    logic [DEPTH:0]      ptr_q, ptr_d;
    logic [LOG2UNIT-1:0] pre_q, pre_d;
    logic [ZW-1:0]       zrun_q, zrun_d;
    logic [DEPTH:0]      len_q, len_d;
    logic                full_q, full_d;
    logic                we_q, we_d;
    logic [DEPTH-1:0]    waddr_q, waddr_d;
    logic                wdata_q, wdata_d;

    logic                key_s;
    logic                tick;
    logic [DEPTH:0]      ptr_inc;
    logic [ZW-1:0]       zrun_nxt;

    assign key_s    = sync_q[1];
    assign tick     = &pre_q;
    assign ptr_inc  = ptr_q + (DEPTH+1)'(1);
    assign zrun_nxt = key_s ? '0 : ((zrun_q == STOP) ? STOP : zrun_q + ZW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sync_q  <= '0;
            ptr_q   <= '0;
            pre_q   <= '0;
            zrun_q  <= '0;
            len_q   <= '0;
            full_q  <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], key_in};
            ptr_q   <= ptr_d;
            pre_q   <= pre_d;
            zrun_q  <= zrun_d;
            len_q   <= len_d;
            full_q  <= full_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        pre_d   = pre_q;
        zrun_d  = zrun_q;
        len_d   = len_q;
        full_d  = full_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                // The key-down edge itself becomes word 0, so every image starts with a mark.
                if (key_s) begin
                    we_d    = 1'b1;
                    waddr_d = '0;
                    wdata_d = 1'b1;
                    ptr_d   = (DEPTH+1)'(1);
                    zrun_d  = '0;
                    pre_d   = '0;
                    state_d = RECORD;
                end
            end
            RECORD: begin
                pre_d = pre_q + LOG2UNIT'(1);
                if (arm) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                    pre_d   = '0;
                    zrun_d  = '0;
                    len_d   = '0;
                    full_d  = 1'b0;
                end else if (tick) begin
                    we_d    = 1'b1;
                    waddr_d = ptr_q[DEPTH-1:0];
                    wdata_d = key_s;
                    ptr_d   = ptr_inc;
                    zrun_d  = zrun_nxt;
                    // Capacity is tested first so a tie between both stop reasons reports full.
                    if (ptr_inc == CAP) begin
                        state_d = DONE;
                        full_d  = 1'b1;
                        len_d   = ptr_inc;
                    end else if (zrun_nxt == STOP) begin
                        state_d = DONE;
                        full_d  = 1'b0;
                        len_d   = ptr_inc;
                    end
                end
            end
            DONE: begin
                if (arm) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                    pre_d   = '0;
                    zrun_d  = '0;
                    len_d   = '0;
                    full_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ram.ram_waddr = {{(11-DEPTH){1'b0}}, waddr_q};
    assign ram.ram_wdata = {15'b0, wdata_q};
    assign ram.ram_we    = we_q;
    assign ram.ram_wclke = we_q;
    assign recording     = (state_q == RECORD);
    assign done          = (state_q == DONE);
    assign full          = full_q;
    assign length        = len_q;
endmodule
